// File: rtl/buzzer_sequencer_pkg.sv
// Shared zone/state encodings and the echo-width classifier for the parking-aid buzzer.
package buzzer_sequencer_pkg;

    typedef enum logic [1:0] {
        ZONE_NEAR = 2'd0,
        ZONE_MID  = 2'd1,
        ZONE_FAR  = 2'd2,
        ZONE_OUT  = 2'd3
    } zone_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TONE_ON  = 2'd1,
        S_TONE_OFF = 2'd2
    } state_t;

    // Thresholds are inclusive upper bounds of each zone.
    function automatic zone_t classify(
        input logic [23:0] v,
        input logic [23:0] th_near,
        input logic [23:0] th_mid,
        input logic [23:0] th_far
    );
        if (v <= th_near)     return ZONE_NEAR;
        else if (v <= th_mid) return ZONE_MID;
        else if (v <= th_far) return ZONE_FAR;
        else                  return ZONE_OUT;
    endfunction

endpackage

// File: rtl/buzzer_sequencer_tone_gen.sv
// Free-running half-period divider producing the buzzer square wave.
// Synchronous clear restarts the wave low with a fresh half-period.
module tone_gen #(
    parameter int TONE_HALF = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tone
);

    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [TW-1:0] TONE_TC = TW'(TONE_HALF - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (cnt == TONE_TC) begin
            cnt  <= '0;
            tone <= ~tone;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/buzzer_sequencer.sv
// Parking-aid buzzer sequencer: classifies echo widths into zones and gates a tone cadence.
//   state      | meaning
//   S_IDLE     | silent; waits for enable with a zone other than OUT
//   S_TONE_ON  | tone sounding; NEAR holds here, MID/FAR time ON_CYC
//   S_TONE_OFF | silent pause of OFF_MID or OFF_FAR, then re-latch zone
module buzzer_sequencer
    import buzzer_sequencer_pkg::*;
#(
    parameter logic [23:0] TH_NEAR   = 24'd23750,
    parameter logic [23:0] TH_MID    = 24'd95000,
    parameter logic [23:0] TH_FAR    = 24'd12500000,
    parameter int          TONE_HALF = 25000,
    parameter int          ON_CYC    = 5000000,
    parameter int          OFF_MID   = 5000000,
    parameter int          OFF_FAR   = 20000000,
    parameter int          STALE_CYC = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        meas_valid,
    input  logic [23:0] meas_value,
    output logic        buzzer,
    output logic [1:0]  zone,
    output logic        active
);

    localparam int BEEP_MAX = (ON_CYC > OFF_MID) ? ((ON_CYC > OFF_FAR) ? ON_CYC : OFF_FAR)
                                                 : ((OFF_MID > OFF_FAR) ? OFF_MID : OFF_FAR);
    localparam int BW = $clog2(BEEP_MAX + 1);
    localparam int SW = $clog2(STALE_CYC + 1);

    localparam logic [BW-1:0] ON_TC    = BW'(ON_CYC - 1);
    localparam logic [BW-1:0] MID_TC   = BW'(OFF_MID - 1);
    localparam logic [BW-1:0] FAR_TC   = BW'(OFF_FAR - 1);
    localparam logic [SW-1:0] STALE_TC = SW'(STALE_CYC - 1);

    zone_t         zone_q;
    zone_t         act_zone;
    zone_t         act_zone_nx;
    state_t        state;
    state_t        state_nx;
    logic [BW-1:0] beep_cnt;
    logic [BW-1:0] beep_cnt_nx;
    logic [BW-1:0] off_tc;
    logic [SW-1:0] stale_cnt;
    logic          tone_clr;
    logic          tone;

    // A fresh strobe always wins over the stale timeout in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zone_q    <= ZONE_OUT;
            stale_cnt <= '0;
        end else if (meas_valid) begin
            zone_q    <= classify(meas_value, TH_NEAR, TH_MID, TH_FAR);
            stale_cnt <= '0;
        end else if (stale_cnt == STALE_TC) begin
            zone_q    <= ZONE_OUT;
        end else begin
            stale_cnt <= stale_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            act_zone <= ZONE_OUT;
            beep_cnt <= '0;
        end else begin
            state    <= state_nx;
            act_zone <= act_zone_nx;
            beep_cnt <= beep_cnt_nx;
        end
    end

    assign off_tc = (act_zone == ZONE_FAR) ? FAR_TC : MID_TC;

    // MID/FAR beeps finish their phase with the zone latched at phase start.
    always_comb begin
        state_nx    = state;
        act_zone_nx = act_zone;
        beep_cnt_nx = '0;
        if (!enable || zone_q == ZONE_OUT) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx    = S_TONE_ON;
                    act_zone_nx = zone_q;
                end
                S_TONE_ON: begin
                    if (act_zone == ZONE_NEAR) begin
                        act_zone_nx = zone_q;
                    end else if (beep_cnt == ON_TC) begin
                        state_nx = S_TONE_OFF;
                    end else begin
                        beep_cnt_nx = beep_cnt + BW'(1);
                    end
                end
                S_TONE_OFF: begin
                    if (beep_cnt == off_tc) begin
                        state_nx    = S_TONE_ON;
                        act_zone_nx = zone_q;
                    end else begin
                        beep_cnt_nx = beep_cnt + BW'(1);
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // The tone only runs while staying in TONE_ON, so it is low everywhere else.
    assign tone_clr = !(state == S_TONE_ON && state_nx == S_TONE_ON);

    tone_gen #(
        .TONE_HALF(TONE_HALF)
    ) u_tone_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (tone_clr),
        .tone (tone)
    );

    assign buzzer = tone;
    assign zone   = zone_q;
    assign active = (state != S_IDLE);

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: elapsed-time reference model checked every cycle,
// plus directed literal checks at the key cadence points.
module tb_buzzer_sequencer;

    localparam int TH    = 4;
    localparam int ON    = 16;
    localparam int OMID  = 16;
    localparam int OFAR  = 48;
    localparam int STALE = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        meas_valid = 1'b0;
    logic [23:0] meas_value = '0;
    logic        buzzer;
    logic [1:0]  zone;
    logic        active;

    int total = 0;
    int bad = 0;

    int bvals[6] = '{23750, 23751, 95000, 95001, 12500000, 12500001};
    int bexp[6]  = '{0, 1, 1, 2, 2, 3};

    buzzer_sequencer #(
        .TONE_HALF (TH),
        .ON_CYC    (ON),
        .OFF_MID   (OMID),
        .OFF_FAR   (OFAR),
        .STALE_CYC (STALE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .meas_valid (meas_valid),
        .meas_value (meas_value),
        .buzzer     (buzzer),
        .zone       (zone),
        .active     (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int zone_of(input int v);
        if (v <= 23750)         return 0;
        else if (v <= 95000)    return 1;
        else if (v <= 12500000) return 2;
        else                    return 3;
    endfunction

    // Reference model: zone from last strobe age, tone from elapsed time in the phase.
    int m_zone = 3;
    int m_idle = 0;
    bit m_run = 1'b0;
    bit m_on = 1'b0;
    int m_az = 3;
    int m_t = 0;
    int m_b = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_zone = 3; m_idle = 0; m_run = 1'b0; m_on = 1'b0;
            m_az = 3; m_t = 0; m_b = 0;
        end else begin : upd
            int z;
            z = m_zone;
            if (!enable || z == 3) begin
                m_run = 1'b0;
            end else if (!m_run) begin
                m_run = 1'b1; m_on = 1'b1; m_az = z; m_t = 0; m_b = 0;
            end else if (m_on) begin
                m_t++;
                if (m_az == 0) begin
                    m_az = z; m_b = 0;
                end else begin
                    m_b++;
                    if (m_b == ON) begin m_on = 1'b0; m_b = 0; end
                end
            end else begin
                m_b++;
                if (m_b == ((m_az == 2) ? OFAR : OMID)) begin
                    m_on = 1'b1; m_az = z; m_t = 0; m_b = 0;
                end
            end
            if (meas_valid) begin
                m_zone = zone_of(int'(meas_value));
                m_idle = 0;
            end else begin
                if (m_idle < STALE) m_idle++;
                if (m_idle >= STALE) m_zone = 3;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_zone", 32'(zone), 32'(m_zone));
            check("model_active", 32'(active), 32'(m_run));
            check("model_buzzer", 32'(buzzer), 32'(m_run && m_on && ((m_t / TH) % 2 == 1)));
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int v);
        meas_valid = 1'b1;
        meas_value = 24'(v);
        wait_edges(1);
        meas_valid = 1'b0;
    endtask

    initial begin
        wait_edges(2);
        check("rst_zone", 32'(zone), 3);
        check("rst_buzzer", 32'(buzzer), 0);
        check("rst_active", 32'(active), 0);
        rst = 1'b0;
        wait_edges(2);

        for (int i = 0; i < 6; i++) begin
            strobe(bvals[i]);
            check("bnd_zone", 32'(zone), 32'(bexp[i]));
        end

        // NEAR: continuous tone
        strobe(100);
        check("near_zone", 32'(zone), 0);
        check("near_idle", 32'(active), 0);
        enable = 1'b1;
        wait_edges(1);
        check("near_entry_active", 32'(active), 1);
        check("near_entry_buzzer", 32'(buzzer), 0);
        wait_edges(3);
        check("near_k3_buzzer", 32'(buzzer), 0);
        wait_edges(1);
        check("near_k4_buzzer", 32'(buzzer), 1);
        for (int i = 0; i < 3; i++) begin
            wait_edges(40);
            strobe(100);
        end
        check("near_still_active", 32'(active), 1);

        // MID cadence
        enable = 1'b0;
        wait_edges(2);
        check("mute_active", 32'(active), 0);
        check("mute_buzzer", 32'(buzzer), 0);
        strobe(50000);
        check("mid_zone", 32'(zone), 1);
        enable = 1'b1;
        wait_edges(1);
        check("mid_entry_active", 32'(active), 1);
        check("mid_entry_buzzer", 32'(buzzer), 0);
        wait_edges(15);
        check("mid_k15_buzzer", 32'(buzzer), 1);
        wait_edges(1);
        check("mid_off_buzzer", 32'(buzzer), 0);
        check("mid_off_active", 32'(active), 1);
        wait_edges(16);
        check("mid_on2_active", 32'(active), 1);
        check("mid_on2_buzzer", 32'(buzzer), 0);
        wait_edges(4);
        check("mid_on2_k4_buzzer", 32'(buzzer), 1);

        // switch MID -> FAR during TONE_ON
        strobe(200000);
        check("far_zone", 32'(zone), 2);
        wait_edges(11);
        check("sw_off_buzzer", 32'(buzzer), 0);
        check("sw_off_active", 32'(active), 1);
        wait_edges(16);
        check("sw_on_active", 32'(active), 1);
        wait_edges(15);
        check("sw_on_k15_buzzer", 32'(buzzer), 1);
        wait_edges(1);
        check("far_off_buzzer", 32'(buzzer), 0);
        wait_edges(20);
        check("far_pause_buzzer", 32'(buzzer), 0);
        check("far_pause_active", 32'(active), 1);
        wait_edges(28);
        check("far_on_buzzer", 32'(buzzer), 0);
        wait_edges(4);
        check("far_on_k4_buzzer", 32'(buzzer), 1);
        wait_edges(1);

        // abort by enable
        enable = 1'b0;
        wait_edges(1);
        check("abort_buzzer", 32'(buzzer), 0);
        check("abort_active", 32'(active), 0);
        enable = 1'b1;
        wait_edges(1);
        check("resume_active", 32'(active), 1);

        // stale timeout
        wait_edges(101);
        check("prestale_zone", 32'(zone), 2);
        wait_edges(1);
        check("stale_zone", 32'(zone), 3);
        wait_edges(1);
        check("stale_active", 32'(active), 0);
        check("stale_buzzer", 32'(buzzer), 0);

        // async reset mid-TONE_ON
        strobe(100);
        check("rs_zone", 32'(zone), 0);
        wait_edges(1);
        check("rs_entry_active", 32'(active), 1);
        wait_edges(5);
        check("rs_k5_buzzer", 32'(buzzer), 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_buzzer", 32'(buzzer), 0);
        check("arst_zone", 32'(zone), 3);
        check("arst_active", 32'(active), 0);
        wait_edges(2);
        rst = 1'b0;
        wait_edges(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
